rx_mod: RTL and testbench



---
 rtl/rx_pkg.sv | 22 ++
 rtl/rx_sat.sv | 36 +++
 rtl/rx_mod.sv | 122 ++++++++++++
 tb/tb_rx_mod.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared constants and matched-filter taps for the BPSK receiver
// Purpose: default widths, oversampling and tap count, the Q1.7 matched-filter
//   table (symmetric, time-reversed transmit pulse, DC gain 272/128 = 2.125)
//   and the decision sign convention.
// Ports: none (package).
package rx_pkg;

  localparam int NBIT    = 8;
  localparam int FBIT    = 7;
  localparam int USAMPLE = 4;
  localparam int LENGTH  = 24;

  // Decision value emitted for a negative filter output.
  localparam logic SYM_NEG = 1'b1;

  localparam logic signed [NBIT-1:0] RX_COEFF [0:LENGTH-1] = '{
    8'sd1,   8'sd2,   8'sd3,   8'sd2,   8'sd0,  -8'sd3,  -8'sd5,  -8'sd2,
    8'sd8,   8'sd25,  8'sd45,  8'sd60,  8'sd60,  8'sd45,  8'sd25,  8'sd8,
    -8'sd2,  -8'sd5,  -8'sd3,  8'sd0,   8'sd2,   8'sd3,   8'sd2,   8'sd1
  };

endpackage

// File: rtl/rx_sat.sv
// rtl/rx_sat.sv - full-precision accumulator to NBIT quantiser with saturation
// Purpose: takes a Q(ACC_BITS-2*FBIT).(2*FBIT) value, truncates toward -inf to
//   Q1.FBIT and clamps to the NBIT range.
// Ports: acc (signed accumulator in), q (signed NBIT result), sat (q clamped).
module rx_sat #(
  parameter int ACC_BITS = 21,
  parameter int NBIT     = 8,
  parameter int FBIT     = 7
) (
  input  logic signed [ACC_BITS-1:0] acc,
  output logic signed [NBIT-1:0]     q,
  output logic                       sat
);

  localparam int TOP = NBIT + FBIT - 1;

  logic [ACC_BITS-1-TOP:0] head;
  logic                    lsb_unused;

  // Fractional bits below the output LSB are simply dropped (floor).
  assign lsb_unused = ^acc[FBIT-1:0];
  assign head       = acc[ACC_BITS-1:TOP];

  always_comb begin
    // The value fits only when every bit from the output sign up is a copy.
    sat = !((&head) || (~|head));
    if (!sat) begin
      q = acc[TOP:FBIT];
    end else if (acc[ACC_BITS-1]) begin
      q = {1'b1, {(NBIT-1){1'b0}}};
    end else begin
      q = {1'b0, {(NBIT-1){1'b1}}};
    end
  end

endmodule

// File: rtl/rx_mod.sv
// rtl/rx_mod.sv - BPSK matched-filter receiver with symbol-rate hard decisions
// Purpose: shifts oversampled Q1.7 samples through a LENGTH-tap matched FIR,
//   outputs the saturated filtered stream and one decision per symbol at the
//   selected phase once the filter is full.
// Ports: clk, rst (async, active-low), enable (sample valid), in_sample (Q1.7),
//   phase_sel (decision phase); filt_out/filt_valid/sat_flag (filtered
//   stream), symbol/symbol_valid (decisions, 1 = negative output).
module rx_mod
  import rx_pkg::*;
#(
  parameter int NBIT     = rx_pkg::NBIT,
  parameter int FBIT     = rx_pkg::FBIT,
  parameter int USAMPLE  = rx_pkg::USAMPLE,
  parameter int LENGTH   = rx_pkg::LENGTH,
  parameter int ACC_BITS = 2*NBIT + $clog2(LENGTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic signed [NBIT-1:0]     in_sample,
  input  logic [$clog2(USAMPLE)-1:0] phase_sel,
  output logic signed [NBIT-1:0]     filt_out,
  output logic                       filt_valid,
  output logic                       sat_flag,
  output logic                       symbol,
  output logic                       symbol_valid
);

  localparam int PW = $clog2(USAMPLE);
  localparam int FW = $clog2(LENGTH + 1);

  logic signed [NBIT-1:0]     taps [0:LENGTH-1];
  logic                       en_q;
  logic [PW-1:0]              phase_cnt;    // phase of the next accepted sample
  logic [FW-1:0]              fill_cnt;
  logic                       accepted_q;   // a sample entered taps last edge
  logic                       decide_q;     // that sample is a decision point

  logic                       rise;
  logic [PW-1:0]              sample_phase;
  logic [FW-1:0]              fill_next;
  logic signed [2*NBIT-1:0]   prod;
  logic signed [ACC_BITS-1:0] acc;
  logic signed [NBIT-1:0]     q_sample;
  logic                       q_sat;

  assign rise = enable && !en_q;

  always_comb begin
    sample_phase = rise ? '0 : phase_cnt;
    if (rise) begin
      fill_next = FW'(1);
    end else if (fill_cnt == FW'(LENGTH)) begin
      fill_next = fill_cnt;
    end else begin
      fill_next = fill_cnt + FW'(1);
    end
  end

  // Full-precision sum over the current shift register contents.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < LENGTH; k++) begin
      prod = (2*NBIT)'(RX_COEFF[k]) * (2*NBIT)'(taps[k]);
      acc  = acc + ACC_BITS'(prod);
    end
  end

  rx_sat #(
    .ACC_BITS (ACC_BITS),
    .NBIT     (NBIT),
    .FBIT     (FBIT)
  ) u_sat (
    .acc (acc),
    .q   (q_sample),
    .sat (q_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LENGTH; k++) taps[k] <= '0;
      en_q         <= 1'b0;
      phase_cnt    <= '0;
      fill_cnt     <= '0;
      accepted_q   <= 1'b0;
      decide_q     <= 1'b0;
      filt_out     <= '0;
      filt_valid   <= 1'b0;
      sat_flag     <= 1'b0;
      symbol       <= 1'b0;
      symbol_valid <= 1'b0;
    end else begin
      en_q <= enable;

      // Output stage: taps now hold the sample accepted on the previous edge.
      filt_valid   <= accepted_q;
      symbol_valid <= decide_q;
      if (accepted_q) begin
        filt_out <= q_sample;
        sat_flag <= q_sat;
      end
      if (decide_q) begin
        symbol <= acc[ACC_BITS-1] ? SYM_NEG : !SYM_NEG;
      end

      accepted_q <= enable;
      decide_q   <= enable && (sample_phase == phase_sel) && (fill_next == FW'(LENGTH));

      if (enable) begin
        // On an enable rise the old history is discarded as the new sample lands.
        for (int k = LENGTH-1; k > 0; k--) begin
          taps[k] <= rise ? '0 : taps[k-1];
        end
        taps[0]   <= in_sample;
        phase_cnt <= (sample_phase == PW'(USAMPLE-1)) ? '0 : sample_phase + PW'(1);
        fill_cnt  <= fill_next;
      end
    end
  end

endmodule

// File: tb/tb_rx_mod.sv
// tb/tb_rx_mod.sv - directed self-checking bench for rx_mod
module tb_rx_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] in_sample;
  logic [1:0] phase_sel;
  logic [7:0] filt_out;
  logic       filt_valid;
  logic       sat_flag;
  logic       symbol;
  logic       symbol_valid;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rx_mod dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_sample    (in_sample),
    .phase_sel    (phase_sel),
    .filt_out     (filt_out),
    .filt_valid   (filt_valid),
    .sat_flag     (sat_flag),
    .symbol       (symbol),
    .symbol_valid (symbol_valid)
  );

  int mc [24]  = '{1, 2, 3, 2, 0, -3, -5, -2, 8, 25, 45, 60,
                   60, 45, 25, 8, -2, -5, -3, 0, 2, 3, 2, 1};
  int imp [24] = '{0, 1, 1, 1, 0, -2, -3, -1, 4, 12, 22, 30,
                   30, 22, 12, 4, -1, -3, -2, 0, 1, 1, 1, 0};
  bit pat [16] = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0};

  // Reference FIR state and one-deep expectation pipeline.
  int   m_tap [24];
  int   m_fill, m_phase, m_idx;
  bit   m_prev_en;
  bit   p_valid, p_dec, p_sat, p_sym;
  int   p_filt, p_idx;
  bit   e_valid, e_dec, e_sat, e_sym;
  logic [7:0] e_filt;
  int   e_idx;

  task automatic model_reset();
    foreach (m_tap[k]) m_tap[k] = 0;
    m_fill = 0; m_phase = 0; m_idx = 0; m_prev_en = 0;
    p_valid = 0; p_dec = 0; p_sat = 0; p_sym = 0; p_filt = 0; p_idx = 0;
    e_valid = 0; e_dec = 0; e_sat = 0; e_sym = 0; e_filt = 8'h00; e_idx = 0;
  endtask

  // Drives one cycle; afterwards e_* hold what the outputs must show.
  task automatic step(input bit en, input logic [7:0] s);
    int a, q;
    e_valid = p_valid;
    e_dec   = p_dec;
    e_idx   = p_idx;
    if (p_valid) begin e_filt = 8'(p_filt); e_sat = p_sat; end
    if (p_dec) e_sym = p_sym;
    p_valid = en;
    p_dec   = 0;
    if (en) begin
      if (!m_prev_en) begin
        foreach (m_tap[k]) m_tap[k] = 0;
        m_phase = 0; m_fill = 0; m_idx = 0;
      end
      for (int k = 23; k > 0; k--) m_tap[k] = m_tap[k-1];
      m_tap[0] = $signed(s);
      m_fill   = (m_fill < 24) ? m_fill + 1 : 24;
      a = 0;
      for (int k = 0; k < 24; k++) a += mc[k] * m_tap[k];
      q = a >>> 7;
      p_sat = (q > 127) || (q < -128);
      p_filt = (q > 127) ? 127 : (q < -128) ? -128 : q;
      p_dec = (m_phase == int'(phase_sel)) && (m_fill == 24);
      p_sym = (a < 0);
      p_idx = m_idx;
      m_idx++;
      m_phase = (m_phase + 1) % 4;
    end
    m_prev_en = en;
    enable    = en;
    in_sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      enable    = 1'($urandom_range(0, 1));
      in_sample = 8'($urandom);
      phase_sel = 2'($urandom);
      @(posedge clk);
      #1;
      total++;
      if ({filt_out, filt_valid, sat_flag, symbol, symbol_valid} !== 12'h000)
        $display("FAIL reset_hold c=%0d got %h required 000", c,
                 {filt_out, filt_valid, sat_flag, symbol, symbol_valid});
      else passes++;
    end
    enable = 1'b0; in_sample = 8'h00; phase_sel = 2'd0;
    #2;
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 8'h33);
      total++;
      if ({filt_out, filt_valid, sat_flag, symbol, symbol_valid} !== 12'h000)
        $display("FAIL reset_idle c=%0d got %h required 000", c,
                 {filt_out, filt_valid, sat_flag, symbol, symbol_valid});
      else passes++;
    end
  endtask

  task automatic test_impulse();
    logic [7:0] ev;
    phase_sel = 2'd3;
    step(1'b0, 8'h00);
    for (int k = 0; k <= 30; k++) begin
      step(k < 30, (k == 0) ? 8'h40 : 8'h00);
      if (k >= 1) begin
        int i = k - 1;
        bit dv = (i >= 23) && (i % 4 == 3);
        ev = (i < 24) ? 8'(imp[i]) : 8'h00;
        total++;
        if (filt_out !== ev) $display("FAIL impulse_filt i=%0d got %h required %h", i, filt_out, ev);
        else passes++;
        total++;
        if (filt_valid !== 1'b1) $display("FAIL impulse_valid i=%0d got %b required 1", i, filt_valid);
        else passes++;
        total++;
        if (symbol_valid !== dv) $display("FAIL impulse_symvalid i=%0d got %b required %b", i, symbol_valid, dv);
        else passes++;
        if (dv) begin
          total++;
          if (symbol !== 1'b0) $display("FAIL impulse_symbol i=%0d got %b required 0", i, symbol);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_dc(input logic [7:0] v, input logic sym_req);
    phase_sel = 2'd2;
    step(1'b0, 8'h00);
    for (int k = 0; k <= 40; k++) begin
      step(k < 40, v);
      if (k >= 1) begin
        int i = k - 1;
        bit dv = (i >= 23) && (i % 4 == 2);
        if (i >= 23) begin
          total++;
          if (filt_out !== v) $display("FAIL dc_filt v=%h i=%0d got %h required %h", v, i, filt_out, v);
          else passes++;
          total++;
          if (sat_flag !== 1'b1) $display("FAIL dc_sat v=%h i=%0d got %b required 1", v, i, sat_flag);
          else passes++;
        end
        total++;
        if (symbol_valid !== dv) $display("FAIL dc_symvalid v=%h i=%0d got %b required %b", v, i, symbol_valid, dv);
        else passes++;
        if (dv) begin
          total++;
          if (symbol !== sym_req) $display("FAIL dc_symbol v=%h i=%0d got %b required %b", v, i, symbol, sym_req);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_symbol_stream();
    int ndec;
    for (int p = 0; p < 4; p++) begin
      phase_sel = 2'(p);
      ndec = 0;
      step(1'b0, 8'h00);
      for (int k = 0; k <= 64; k++) begin
        step(k < 64, (k < 64 && pat[k/4]) ? 8'hC0 : 8'h40);
        if (k >= 1) begin
          total++;
          if (filt_out !== e_filt) $display("FAIL stream_filt p=%0d i=%0d got %h required %h", p, e_idx, filt_out, e_filt);
          else passes++;
          total++;
          if (symbol_valid !== e_dec) $display("FAIL stream_symvalid p=%0d i=%0d got %b required %b", p, e_idx, symbol_valid, e_dec);
          else passes++;
          if (symbol_valid) ndec++;
          if (e_dec) begin
            total++;
            if (symbol !== e_sym) $display("FAIL stream_symbol p=%0d i=%0d got %b required %b", p, e_idx, symbol, e_sym);
            else passes++;
            if (p < 3) begin
              total++;
              if (symbol !== pat[e_idx/4 - 3])
                $display("FAIL stream_delay p=%0d i=%0d got %b required %b", p, e_idx, symbol, pat[e_idx/4 - 3]);
              else passes++;
            end
          end
        end
      end
      total++;
      if (ndec !== ((p == 3) ? 11 : 10)) $display("FAIL stream_count p=%0d got %0d required %0d", p, ndec, (p == 3) ? 11 : 10);
      else passes++;
    end
  endtask

  task automatic test_enable_gap();
    phase_sel = 2'd1;
    step(1'b0, 8'h00);
    for (int k = 0; k < 31; k++) step(1'b1, pat[(k/4) % 16] ? 8'hC0 : 8'h40);
    for (int g = 0; g < 10; g++) begin
      step(1'b0, 8'h5A);
      total++;
      if (filt_valid !== (g == 0)) $display("FAIL gap_valid g=%0d got %b required %b", g, filt_valid, g == 0);
      else passes++;
      total++;
      if (filt_out !== e_filt) $display("FAIL gap_hold g=%0d got %h required %h", g, filt_out, e_filt);
      else passes++;
      if (g > 0) begin
        total++;
        if (symbol_valid !== 1'b0) $display("FAIL gap_symvalid g=%0d got %b required 0", g, symbol_valid);
        else passes++;
      end
    end
    for (int k = 0; k <= 30; k++) begin
      step(1'b1, pat[(k/4) % 16] ? 8'hC0 : 8'h40);
      if (k == 0) begin
        total++;
        if (filt_valid !== 1'b0) $display("FAIL regap_valid got %b required 0", filt_valid);
        else passes++;
      end else begin
        int i = k - 1;
        bit dv = (i >= 23) && (i % 4 == 1);
        total++;
        if (symbol_valid !== dv) $display("FAIL regap_symvalid i=%0d got %b required %b", i, symbol_valid, dv);
        else passes++;
        total++;
        if (filt_out !== e_filt) $display("FAIL regap_filt i=%0d got %h required %h", i, filt_out, e_filt);
        else passes++;
      end
    end
  endtask

  task automatic test_async_reset();
    phase_sel = 2'd0;
    step(1'b0, 8'h00);
    for (int k = 0; k < 38; k++) step(1'b1, 8'hC0);
    total++;
    if ({symbol_valid, symbol, filt_out} !== 10'h380)
      $display("FAIL prereset_state got %h required 380", {symbol_valid, symbol, filt_out});
    else passes++;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({filt_out, filt_valid, sat_flag, symbol, symbol_valid} !== 12'h000)
      $display("FAIL async_clear got %h required 000", {filt_out, filt_valid, sat_flag, symbol, symbol_valid});
    else passes++;
    enable = 1'b1; in_sample = 8'hC0;
    @(posedge clk);
    #1;
    total++;
    if ({filt_out, filt_valid, sat_flag, symbol, symbol_valid} !== 12'h000)
      $display("FAIL async_held got %h required 000", {filt_out, filt_valid, sat_flag, symbol, symbol_valid});
    else passes++;
    #2;
    rst = 1'b1;
    model_reset();
    for (int k = 0; k <= 30; k++) begin
      step(1'b1, 8'hC0);
      if (k >= 1) begin
        int i = k - 1;
        bit dv = (i >= 24) && (i % 4 == 0);
        total++;
        if (symbol_valid !== dv) $display("FAIL rewarm_symvalid i=%0d got %b required %b", i, symbol_valid, dv);
        else passes++;
        if (i >= 23) begin
          total++;
          if (filt_out !== 8'h80) $display("FAIL rewarm_filt i=%0d got %h required 80", i, filt_out);
          else passes++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; in_sample = 8'h00; phase_sel = 2'd0;
    model_reset();
    test_reset();
    test_impulse();
    test_dc(8'h7F, 1'b0);
    test_dc(8'h80, 1'b1);
    test_symbol_stream();
    test_enable_gap();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
